// File: rtl/stream_fifo.sv
// First-word fall-through stream FIFO with count-decoded status flags.
// It can either stall the writer when full or accept and discard the word while counting the drops.
module stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter int AFULL_LVL  = DATA_DEPTH - 1,
    parameter int AEMPTY_LVL = 1,
    parameter int DROP_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(DATA_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty,
    output logic                          last_data,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [15:0]                   drop_cnt
);

    localparam int PTR_W = $clog2(DATA_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam bit DROP  = (DROP_MODE != 0);

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
    logic                  push, pop, drop;

    assign count        = count_q;
    assign full         = (count_q == CNT_W'(DATA_DEPTH));
    assign empty        = (count_q == '0);
    assign last_data    = (count_q == CNT_W'(1));
    assign almost_full  = (count_q >= CNT_W'(AFULL_LVL));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_LVL));
    assign drop_cnt     = drop_cnt_q;

    assign in_ready  = DROP ? 1'b1 : !full;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];

    // In drop mode a full FIFO only takes a word when a pop frees the slot on the same edge.
    assign pop  = out_valid && out_ready && !flush;
    assign push = in_valid && in_ready && !flush && (!full || pop);
    assign drop = DROP && in_valid && !flush && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; stale words are unreachable while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: one backpressure instance and one drop-mode instance share stimulus.
module tb_stream_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0, full0, empty0, last0, af0, ae0;
    logic [DW-1:0] out_data0;
    logic [3:0]    count0;
    logic [15:0]   drop0;

    logic          in_ready1, out_valid1, full1, empty1, last1, af1, ae1;
    logic [DW-1:0] out_data1;
    logic [3:0]    count1;
    logic [15:0]   drop1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .DROP_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .count(count0), .full(full0), .empty(empty0), .last_data(last0),
        .almost_full(af0), .almost_empty(ae0), .drop_cnt(drop0)
    );

    stream_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .DROP_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .count(count1), .full(full1), .empty(empty1), .last_data(last1),
        .almost_full(af1), .almost_empty(ae1), .drop_cnt(drop1)
    );

    typedef struct {
        logic          flush;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        int            ecnt;
        logic [DW-1:0] ehead;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected flags follow from the expected occupancy of the backpressure instance.
    task automatic check0(input string tag, input int ecnt, input logic [DW-1:0] ehead);
        chk({tag, " count"}, DW'(count0), DW'(ecnt));
        chk({tag, " out_valid"}, DW'(out_valid0), DW'(ecnt != 0));
        chk({tag, " empty"}, DW'(empty0), DW'(ecnt == 0));
        chk({tag, " full"}, DW'(full0), DW'(ecnt == DEPTH));
        chk({tag, " last"}, DW'(last0), DW'(ecnt == 1));
        chk({tag, " afull"}, DW'(af0), DW'(ecnt >= DEPTH - 1));
        chk({tag, " aempty"}, DW'(ae0), DW'(ecnt <= 1));
        chk({tag, " in_ready"}, DW'(in_ready0), DW'(ecnt != DEPTH));
        if (ecnt != 0) chk({tag, " out_data"}, out_data0, ehead);
    endtask

    task automatic check1(input string tag, input int ecnt, input logic [DW-1:0] ehead, input int edrop);
        chk({tag, " d1 count"}, DW'(count1), DW'(ecnt));
        chk({tag, " d1 full"}, DW'(full1), DW'(ecnt == DEPTH));
        chk({tag, " d1 in_ready"}, DW'(in_ready1), 1);
        chk({tag, " d1 drop_cnt"}, DW'(drop1), DW'(edrop));
        if (ecnt != 0) chk({tag, " d1 out_data"}, out_data1, ehead);
    endtask

    task automatic step(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy);
        @(negedge clk);
        flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic f, input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input int ecnt, input logic [DW-1:0] ehead);
        vec_t v;
        v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy; v.ecnt = ecnt; v.ehead = ehead;
        tbl.push_back(v);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check0("async rst", 0, '0);
        chk("async rst d1 drop", DW'(drop1), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        // fill to full, blocked ninth write, drain in order
        for (int k = 1; k <= 8; k++) add(0, 1, DW'(k), 0, k, 1);
        add(0, 1, 9, 0, 8, 1);
        for (int j = 1; j <= 8; j++) add(0, 0, 0, 1, 8 - j, DW'(j + 1));
        // push 6 / pop 6 / push 5 / pop 5 across the pointer wrap
        for (int k = 0; k < 6; k++) add(0, 1, DW'('h10 + k), 0, k + 1, 'h10);
        for (int j = 1; j <= 6; j++) add(0, 0, 0, 1, 6 - j, DW'('h10 + j));
        for (int k = 0; k < 5; k++) add(0, 1, DW'('h20 + k), 0, k + 1, 'h20);
        for (int j = 1; j <= 5; j++) add(0, 0, 0, 1, 5 - j, DW'('h20 + j));
        // simultaneous push/pop holding count at 3
        for (int k = 0; k < 3; k++) add(0, 1, DW'('h30 + k), 0, k + 1, 'h30);
        for (int i = 0; i < 10; i++) add(0, 1, DW'('h33 + i), 1, 3, DW'('h31 + i));
        add(0, 1, 'h3D, 0, 4, 'h3A);
        add(0, 1, 'h3E, 0, 5, 'h3A);
        // flush beats a concurrent write and pop
        add(1, 1, 'hEE, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 1, 'h77, 1, 1, 'h77);
        add(0, 0, 0, 1, 0, 0);

        #1;
        check0("reset", 0, '0);
        chk("reset d1 drop", DW'(drop1), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check0($sformatf("vec%0d", i), tbl[i].ecnt, tbl[i].ehead);
        end
        check1("after flush", 0, '0, 0);

        // asynchronous reset at count 4, then first write lands at the head
        for (int k = 0; k < 4; k++) step(0, 1, DW'('h60 + k), 0);
        check0("pre rst", 4, 'h60);
        pulse_rst();
        step(0, 1, 'hA5, 0);
        check0("post rst push", 1, 'hA5);
        check1("post rst push", 1, 'hA5, 0);

        // drop mode: discard while full, accept with a simultaneous pop
        pulse_rst();
        for (int k = 0; k < 8; k++) step(0, 1, DW'('h50 + k), 0);
        check1("drop fill", 8, 'h50, 0);
        for (int k = 0; k < 3; k++) step(0, 1, DW'('h90 + k), 0);
        check1("drop 3", 8, 'h50, 3);
        check0("blocked bp", 8, 'h50);
        chk("bp drop_cnt", DW'(drop0), 0);
        step(0, 1, 'h99, 1);
        check1("full push+pop", 8, 'h51, 3);
        check0("bp pop only", 7, 'h51);
        for (int j = 1; j <= 7; j++) begin
            step(0, 0, 0, 1);
            check1($sformatf("drain%0d", j), 8 - j, (j == 7) ? DW'('h99) : DW'('h51 + j), 3);
        end
        step(0, 0, 0, 1);
        check1("drained", 0, '0, 3);
        chk("drained empty", DW'(empty1), 1);
        step(1, 1, 'h42, 0);
        check1("flush drop_cnt", 0, '0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the data word in bits.
REQ-002 SHALL have parameter DATA_DEPTH, default 8, number of entries; power of two, at least 2.
REQ-003 SHALL have parameter AFULL_LVL, default DATA_DEPTH-1, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AEMPTY_LVL, default 1, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have parameter DROP_MODE, default 0; 0 applies backpressure when full, 1 accepts and discards input when full.
REQ-006 SHALL have the following ports, one per line.
  clk  in  1  sole clock; all state changes on the rising edge.
  rst  in  1  reset; asynchronous and active-high.
  flush  in  1  synchronous clear of contents, pointers and count.
  in_data  in  DATA_WIDTH  write data.
  in_valid  in  1  write request.
  in_ready  out  1  write accept.
  out_data  out  DATA_WIDTH  head-of-queue data (first-word fall-through).
  out_valid  out  1  head entry valid.
  out_ready  in  1  read accept by consumer.
  count  out  clog2(DATA_DEPTH)+1  current occupancy.
  full / empty / last_data  out  1 each  count==DATA_DEPTH / count==0 / count==1.
  almost_full / almost_empty  out  1 each  count>=AFULL_LVL / count<=AEMPTY_LVL.
  drop_cnt  out  16  saturating count of discarded writes (DROP_MODE=1 only; 0 otherwise).

Function
REQ-007 A push SHALL occur on a rising edge where in_valid and in_ready are both 1 and flush is 0.
REQ-008 A pop SHALL occur on a rising edge where out_valid and out_ready are both 1 and flush is 0.
REQ-009 in_ready SHALL be !full when DROP_MODE=0, and constant 1 when DROP_MODE=1.
REQ-010 out_valid SHALL equal !empty; out_data SHALL combinationally present the entry at the read pointer with zero latency.
REQ-011 A push SHALL write in_data at the write pointer and increment it modulo DATA_DEPTH, wrapping DATA_DEPTH-1 to 0.
REQ-012 A pop SHALL increment the read pointer modulo DATA_DEPTH, with the same wrap.
REQ-013 count SHALL update on the same edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-014 When full, simultaneous push and pop SHALL NOT occur when DROP_MODE=0, because in_ready is 0.
REQ-015 When empty, a pop SHALL NOT occur; a same-cycle write SHALL become visible on out_data on the following cycle (no bypass).
REQ-016 When DROP_MODE=1 and full, in_valid=1 with no pop SHALL discard the data, leave pointers and count unchanged, and increment drop_cnt.
REQ-017 When DROP_MODE=1 and full, in_valid=1 together with a pop SHALL be accepted as a normal simultaneous push and pop.
REQ-018 drop_cnt SHALL saturate at 16'hFFFF.
REQ-019 flush=1 SHALL, on the next edge, zero both pointers, count and drop_cnt; it SHALL override any push or pop in that cycle.
REQ-020 All status outputs SHALL be decoded combinationally from count, with no added latency.
REQ-021 The storage array SHALL NOT require reset; its contents are don't-care while empty.

Reset
REQ-022 While rst=1, pointers, count and drop_cnt SHALL be 0 immediately, without waiting for a clock edge.
REQ-023 Reset values SHALL be: empty=1, out_valid=0, full=0, last_data=0, almost_empty=1, almost_full=0, in_ready=1.
REQ-024 Assertion of rst mid-transfer SHALL abort the transfer; the first push after release SHALL land in entry 0.

Verification
REQ-025 Fill/drain (DEPTH=8, DROP_MODE=0): push 1..8 -> full=1, in_ready=0, count=8; a 9th push is blocked; then pop 8 -> data 1..8 in order, empty=1.
REQ-026 Wrap: push 6, pop 6, then push 5 -> out_data sequence continues correctly across pointer wrap; count=5, almost_full=0.
REQ-027 Simultaneous push and pop at count=3 for 10 cycles -> count stays 3 and order is preserved.
REQ-028 Drop mode (DROP_MODE=1): fill 8, then 3 pushes with out_ready=0 -> drop_cnt=3 and contents unchanged; a push with a pop at full -> accepted, count=8.
REQ-029 Flush at count=5 with in_valid=1 -> next cycle count=0, empty=1, and the write is not stored.
REQ-030 Asynchronous rst pulsed between clock edges at count=4 -> empty=1 before the next edge; after release, push 0xA5 -> out_data=0xA5.
